change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Output-side actuator controller for the cola vending machine.
- Consumes the vending FSM's one-cycle cola strobe and change amount (in 0.5-yuan units).
- Drives the cola motor, the 1-yuan coin hopper and the 0.5-yuan coin hopper, one item at a time, with a pulse/done handshake per item.
- Accumulates requests that arrive while busy, so the upstream FSM needs no backpressure.

Parameters:
AMT_W, 5, width of change amount (0.5-yuan units)
PULSE_LEN, 4, cycles an actuator drive pulse is held high (>=1)
ACK_TIMEOUT, 1000, cycles allowed after pulse end for done before fault
COLA_W, 3, width of pending-cola counter

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
cola_in  in  1  one-cycle strobe: dispense one cola
change_in  in  AMT_W  change request; any nonzero value in a cycle is added to pending change
cola_motor  out  1  cola motor drive pulse
cola_done  in  1  cola-drop sensor, one-cycle
hop_1y  out  1  1-yuan hopper drive pulse
hop_1y_done  in  1  1-yuan coin sensor, one-cycle
hop_05  out  1  0.5-yuan hopper drive pulse
hop_05_done  in  1  0.5-yuan coin sensor, one-cycle
busy  out  1  high when state != IDLE
fault  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - rst=1 at an edge: state=IDLE, all outputs 0, pending change rem=0, pending cola cnt=0, timers 0.
  - Mid-operation reset drops any active pulse on the next edge and discards all pending work.
- Pending registers:
  - rem_next = sat(rem - dec + change_in); saturates at 2^AMT_W-1. dec is 2 for a completed 1-yuan coin, 1 for a completed 0.5-yuan coin, else 0.
  - cola cnt_next = sat(cnt - cola_dec + cola_in); saturates at 2^COLA_W-1.
  - A new request and a completion in the same cycle are both applied.
- States:
  - IDLE, COLA_DRIVE, COLA_WAIT, COIN_SEL, COIN_DRIVE, COIN_WAIT, FAULT.
  - Outputs are Moore-decoded from the state register. cola_motor is high only in COLA_DRIVE. hop_1y/hop_05 are high only in COIN_DRIVE, according to the latched selection.
- IDLE:
  - Cola has priority: if cnt!=0 go to COLA_DRIVE.
  - Else if rem!=0 go to COIN_SEL.
  - Else stay.
- Latency: a request strobed in cycle N is visible to IDLE in N+1. The cola pulse is first high in N+2; a coin pulse is first high in N+3.
- COIN_SEL (1 cycle): latch sel=1Y if rem>=2, else sel=05; then go to COIN_DRIVE.
- DRIVE states:
  - Held exactly PULSE_LEN cycles.
  - The matching done is latched if seen during DRIVE. At pulse end: if done was latched, decrement and go to IDLE; else go to WAIT.
- WAIT states:
  - On the matching done: decrement, go to IDLE.
  - Timer counts from 0. If ACK_TIMEOUT cycles elapse without done, go to FAULT with no decrement.
- Done inputs from a non-selected actuator are ignored in every state.
- FAULT: all drives low, fault=1, busy=1, requests ignored; exit only via rst.
- Between consecutive items there is at least one IDLE cycle (cola) or IDLE+COIN_SEL cycles (coin).

Optional Feature:
DISPENSE_STATS_EN:
- Defined: adds outputs cnt_cola, cnt_1y, cnt_05 (each 16 bits). Each increments on its completed dispense, wraps at 2^16, and is cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package change_dispenser_pkg: state encoding constants and coin-select encoding (SEL_1Y, SEL_05).
- One sub-module, dispense_timer: shared pulse-length/timeout counter with load, run and expire. Instantiated once, reused by cola and coin paths.

Test Plan:
- Coin breakdown: change_in=5 for one cycle, each done returned 2 cycles after pulse end -> hop_1y pulses twice, then hop_05 once; rem reaches 0; busy falls.
- Cola priority: cola_in=1 and change_in=1 in the same cycle -> one cola_motor pulse of PULSE_LEN cycles first, then one hop_05 pulse.
- Accumulation: change_in=4, then change_in=3 during the first hop_1y pulse -> 3 hop_1y pulses + 1 hop_05 pulse total.
- Timeout: no hop_1y_done after one pulse -> fault=1 exactly ACK_TIMEOUT cycles after pulse end; drives stay 0; further requests ignored until rst.
- Reset mid-operation: rst=1 during COIN_DRIVE -> hop_1y=0 and busy=0 the next cycle; no further pulses after rst deasserts.
- Saturation: change_in=31 in two consecutive cycles -> rem=31 -> 15 hop_1y + 1 hop_05. With DISPENSE_STATS_EN: cnt_1y=15, cnt_05=1.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared state encoding, coin-select encoding and the
// saturating pending-work update used by the change dispenser.
package change_dispenser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_COLA_DRIVE = 3'd1,
      ST_COLA_WAIT  = 3'd2,
      ST_COIN_SEL   = 3'd3,
      ST_COIN_DRIVE = 3'd4,
      ST_COIN_WAIT  = 3'd5,
      ST_FAULT      = 3'd6
   } state_t;

   typedef enum logic {
      SEL_05 = 1'b0,
      SEL_1Y = 1'b1
   } coin_sel_t;

   // cur + inc - dec, floored at 0 and clamped to max_v.
   function automatic int unsigned sat_update(input int unsigned cur,
                                              input int unsigned inc,
                                              input int unsigned dec,
                                              input int unsigned max_v);
      int unsigned sum;
      sum = cur + inc;
      sum = (sum > dec) ? (sum - dec) : 0;
      return (sum > max_v) ? max_v : sum;
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request strobes from the vending FSM, actuator drive
// pulses, actuator done sensors and status flags of the change dispenser.
//
// Handshake: cola_in/change_in are fire-and-forget one-cycle requests with
// no backpressure. Each actuator drive (cola_motor, hop_1y, hop_05) is a
// Moore pulse; the actuator answers with a one-cycle *_done at any time
// during or after the pulse. A done from an actuator that is not currently
// being driven is ignored.
interface change_dispenser_if #(parameter int AMT_W = 5);
   logic             cola_in;
   logic [AMT_W-1:0] change_in;
   logic             cola_motor;
   logic             cola_done;
   logic             hop_1y;
   logic             hop_1y_done;
   logic             hop_05;
   logic             hop_05_done;
   logic             busy;
   logic             fault;

   // Environment side: issues requests and returns actuator done sensors.
   modport master (
      output cola_in, change_in, cola_done, hop_1y_done, hop_05_done,
      input  cola_motor, hop_1y, hop_05, busy, fault
   );

   // Dispenser side.
   modport slave (
      input  cola_in, change_in, cola_done, hop_1y_done, hop_05_done,
      output cola_motor, hop_1y, hop_05, busy, fault
   );
endinterface

// File: rtl/change_dispenser_timer.sv
// dispense_timer: shared cycle counter for pulse length and done timeout.
// load clears the count; while run is high it counts up and flags expire
// in the cycle where the count reaches limit-1.
module dispense_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         run_i,
   input  logic [W-1:0] limit_i,
   output logic         expire_o
);

   logic [W-1:0] count_q, count_d;

   assign expire_o = run_i && (count_q == (limit_i - W'(1)));

   // Next count: clear on load, advance while running until expiry.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = '0;
      end else if (run_i && !expire_o) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: drives the cola motor and the 1-yuan / 0.5-yuan coin
// hoppers one item at a time from accumulated cola and change requests.
// Optional build macro DISPENSE_STATS_EN adds 16-bit completion counters
// cnt_cola, cnt_1y and cnt_05.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int AMT_W       = 5,
   parameter int PULSE_LEN   = 4,
   parameter int ACK_TIMEOUT = 1000,
   parameter int COLA_W      = 3
) (
   input  logic                clk,
   input  logic                rst,
   change_dispenser_if.slave   bus,
   output state_t              state_o
`ifdef DISPENSE_STATS_EN
   ,
   output logic [15:0]         cnt_cola,
   output logic [15:0]         cnt_1y,
   output logic [15:0]         cnt_05
`endif
);

   localparam int TMR_MAX = (ACK_TIMEOUT > PULSE_LEN) ? ACK_TIMEOUT : PULSE_LEN;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int unsigned REM_MAX = (1 << AMT_W) - 1;
   localparam int unsigned CNT_MAX = (1 << COLA_W) - 1;

   state_t            state_q, state_d;
   coin_sel_t         sel_q, sel_d;
   logic              seen_q, seen_d;
   logic [AMT_W-1:0]  rem_q, rem_d;
   logic [COLA_W-1:0] cnt_q, cnt_d;
   logic              cola_dec;
   logic [1:0]        coin_dec;
   logic              coin_done;
   logic              tmr_load, tmr_run, tmr_exp;
   logic [TMR_W-1:0]  tmr_limit;

   // Done sensor of whichever hopper is currently selected.
   assign coin_done = (sel_q == SEL_1Y) ? bus.hop_1y_done : bus.hop_05_done;

   // The timer restarts on every state change, so each DRIVE and WAIT
   // state sees a count starting at 0.
   assign tmr_load = (state_d != state_q);

   dispense_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (tmr_load),
      .run_i    (tmr_run),
      .limit_i  (tmr_limit),
      .expire_o (tmr_exp)
   );

   // Next-state, coin selection, done latch and completion decrements.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      seen_d    = seen_q;
      tmr_run   = 1'b0;
      tmr_limit = TMR_W'(PULSE_LEN);
      cola_dec  = 1'b0;
      coin_dec  = 2'd0;
      case (state_q)
         ST_IDLE: begin
            seen_d = 1'b0;
            if (cnt_q != '0)      state_d = ST_COLA_DRIVE;
            else if (rem_q != '0) state_d = ST_COIN_SEL;
         end
         ST_COLA_DRIVE: begin
            tmr_run = 1'b1;
            if (bus.cola_done) seen_d = 1'b1;
            if (tmr_exp) begin
               if (seen_q || bus.cola_done) begin
                  cola_dec = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_COLA_WAIT;
               end
            end
         end
         ST_COLA_WAIT: begin
            tmr_run   = 1'b1;
            tmr_limit = TMR_W'(ACK_TIMEOUT);
            if (bus.cola_done) begin
               cola_dec = 1'b1;
               state_d  = ST_IDLE;
            end else if (tmr_exp) begin
               state_d  = ST_FAULT;
            end
         end
         ST_COIN_SEL: begin
            seen_d  = 1'b0;
            sel_d   = (rem_q >= AMT_W'(2)) ? SEL_1Y : SEL_05;
            state_d = ST_COIN_DRIVE;
         end
         ST_COIN_DRIVE: begin
            tmr_run = 1'b1;
            if (coin_done) seen_d = 1'b1;
            if (tmr_exp) begin
               if (seen_q || coin_done) begin
                  coin_dec = (sel_q == SEL_1Y) ? 2'd2 : 2'd1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_COIN_WAIT;
               end
            end
         end
         ST_COIN_WAIT: begin
            tmr_run   = 1'b1;
            tmr_limit = TMR_W'(ACK_TIMEOUT);
            if (coin_done) begin
               coin_dec = (sel_q == SEL_1Y) ? 2'd2 : 2'd1;
               state_d  = ST_IDLE;
            end else if (tmr_exp) begin
               state_d  = ST_FAULT;
            end
         end
         default: begin
            // ST_FAULT: terminal until reset.
            state_d = ST_FAULT;
         end
      endcase
   end

   // Pending work: new requests and completions apply in the same cycle;
   // a faulted dispenser ignores new requests.
   always_comb begin
      rem_d = rem_q;
      cnt_d = cnt_q;
      if (state_q != ST_FAULT) begin
         rem_d = AMT_W'(sat_update(32'(rem_q), 32'(bus.change_in),
                                   32'(coin_dec), REM_MAX));
         cnt_d = COLA_W'(sat_update(32'(cnt_q), 32'(bus.cola_in),
                                    32'(cola_dec), CNT_MAX));
      end
   end

   // State and pending-work registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_05;
         seen_q  <= 1'b0;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         seen_q  <= seen_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore outputs decoded from the state register.
   assign bus.cola_motor = (state_q == ST_COLA_DRIVE);
   assign bus.hop_1y     = (state_q == ST_COIN_DRIVE) && (sel_q == SEL_1Y);
   assign bus.hop_05     = (state_q == ST_COIN_DRIVE) && (sel_q == SEL_05);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.fault      = (state_q == ST_FAULT);
   assign state_o        = state_q;

`ifdef DISPENSE_STATS_EN
   // Completion counters, wrapping at 2^16.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_cola <= '0;
         cnt_1y   <= '0;
         cnt_05   <= '0;
      end else begin
         if (cola_dec)        cnt_cola <= cnt_cola + 16'd1;
         if (coin_dec == 2'd2) cnt_1y  <= cnt_1y + 16'd1;
         if (coin_dec == 2'd1) cnt_05  <= cnt_05 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed bench for change_dispenser with an actuator
// model that returns done pulses and checks pulse kind/order/length.
module tb_change_dispenser;
   import change_dispenser_pkg::*;

   localparam int AMT_W       = 5;
   localparam int PULSE_LEN   = 4;
   localparam int ACK_TIMEOUT = 1000;
   localparam int COLA_W      = 3;

   localparam logic [2:0] P_COLA = 3'b100;
   localparam logic [2:0] P_1Y   = 3'b010;
   localparam logic [2:0] P_05   = 3'b001;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   change_dispenser_if #(.AMT_W(AMT_W)) bus();
   state_t state_o;
`ifdef DISPENSE_STATS_EN
   logic [15:0] cnt_cola, cnt_1y, cnt_05;
`endif

   change_dispenser #(
      .AMT_W(AMT_W), .PULSE_LEN(PULSE_LEN),
      .ACK_TIMEOUT(ACK_TIMEOUT), .COLA_W(COLA_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state_o)
`ifdef DISPENSE_STATS_EN
      ,
      .cnt_cola(cnt_cola),
      .cnt_1y  (cnt_1y),
      .cnt_05  (cnt_05)
`endif
   );

   // Done sources: actuator model plus direct injection from the main flow.
   logic mon_cola_done = 1'b0, mon_1y_done = 1'b0, mon_05_done = 1'b0;
   logic drv_cola_done = 1'b0, drv_1y_done = 1'b0, drv_05_done = 1'b0;
   assign bus.cola_done   = mon_cola_done | drv_cola_done;
   assign bus.hop_1y_done = mon_1y_done   | drv_1y_done;
   assign bus.hop_05_done = mon_05_done   | drv_05_done;

   // ---------------- scoreboard ----------------
   logic [2:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int pulse_starts = 0;
   logic mon_abort  = 1'b0;
   logic resp_en    = 1'b1;
   logic resp_early = 1'b0;
   int   resp_delay = 2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      int n;
      n = 0;
      while ((bus.busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic do_reset();
      mon_abort     = 1'b1;
      rst           = 1'b1;
      bus.cola_in   = 1'b0;
      bus.change_in = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      mon_abort = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- actuator model / pulse monitor ----------------
   initial begin : actuator
      logic [2:0] cur, prev_code, resp_code, want;
      int len, cd;
      prev_code = 3'b000;
      resp_code = 3'b000;
      len = 0;
      cd  = -1;
      forever begin
         tick();
         mon_cola_done = 1'b0;
         mon_1y_done   = 1'b0;
         mon_05_done   = 1'b0;
         cur = {bus.cola_motor, bus.hop_1y, bus.hop_05};
         if (mon_abort) begin
            prev_code = 3'b000;
            len = 0;
            cd  = -1;
         end else begin
            if (cur != 3'b000 && prev_code == 3'b000) begin
               pulse_starts++;
               if (exp_q.size() == 0) begin
                  check("pulse_unexpected", 32'(cur), 32'd0);
               end else begin
                  want = exp_q.pop_front();
                  check("pulse_kind", 32'(cur), 32'(want));
               end
               len = 1;
               resp_code = cur;
            end else if (cur != 3'b000) begin
               len++;
            end else if (prev_code != 3'b000) begin
               check("pulse_len", 32'(len), 32'(PULSE_LEN));
               if (resp_en && !resp_early) cd = resp_delay;
            end
            if ((cur != 3'b000 && resp_en && resp_early && len == 2) || cd == 0) begin
               case (resp_code)
                  P_COLA:  mon_cola_done = 1'b1;
                  P_1Y:    mon_1y_done   = 1'b1;
                  default: mon_05_done   = 1'b1;
               endcase
               cd = -1;
            end else if (cd > 0) begin
               cd--;
            end
            prev_code = cur;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int n, ps0;
      bus.cola_in   = 1'b0;
      bus.change_in = '0;

      // Reset state
      do_reset();
      check("rst_busy",   32'(bus.busy), 32'd0);
      check("rst_fault",  32'(bus.fault), 32'd0);
      check("rst_drives", 32'({bus.cola_motor, bus.hop_1y, bus.hop_05}), 32'd0);
      check("rst_state",  32'(state_o), 32'(ST_IDLE));

      // Coin breakdown: 5 half-yuan units -> 1Y, 1Y, 0.5
      resp_delay = 2;
      exp_q.push_back(P_1Y); exp_q.push_back(P_1Y); exp_q.push_back(P_05);
      bus.change_in = AMT_W'(5);
      tick();                                   // N+1
      bus.change_in = '0;
      check("brk_n1_busy", 32'(bus.busy), 32'd0);
      tick();                                   // N+2
      check("brk_n2_busy", 32'(bus.busy), 32'd1);
      check("brk_n2_hop",  32'(bus.hop_1y), 32'd0);
      tick();                                   // N+3
      check("brk_n3_hop",  32'(bus.hop_1y), 32'd1);
      wait_quiet("brk_done", 200);
      repeat (5) tick();
      check("brk_idle", 32'(bus.busy), 32'd0);

      // Cola priority, dones returned during the drive pulse
      resp_early = 1'b1;
      exp_q.push_back(P_COLA); exp_q.push_back(P_05);
      bus.cola_in   = 1'b1;
      bus.change_in = AMT_W'(1);
      tick();                                   // N+1
      bus.cola_in   = 1'b0;
      bus.change_in = '0;
      check("cola_n1_motor", 32'(bus.cola_motor), 32'd0);
      tick();                                   // N+2
      check("cola_n2_motor", 32'(bus.cola_motor), 32'd1);
      check("cola_n2_hop05", 32'(bus.hop_05), 32'd0);
      wait_quiet("cola_done", 200);
      resp_early = 1'b0;

      // Accumulation: 4 then 3 more during the first 1Y pulse
      resp_delay = 1;
      exp_q.push_back(P_1Y); exp_q.push_back(P_1Y);
      exp_q.push_back(P_1Y); exp_q.push_back(P_05);
      ps0 = pulse_starts;
      bus.change_in = AMT_W'(4);
      tick();
      bus.change_in = '0;
      n = 0;
      while (!bus.hop_1y && n < 20) begin tick(); n++; end
      check("acc_first_pulse", 32'(bus.hop_1y), 32'd1);
      bus.change_in = AMT_W'(3);
      tick();
      bus.change_in = '0;
      wait_quiet("acc_done", 300);
      check("acc_pulses", 32'(pulse_starts - ps0), 32'd4);

      // Reset in the middle of a 1Y drive pulse
      exp_q.push_back(P_1Y);
      bus.change_in = AMT_W'(2);
      tick();
      bus.change_in = '0;
      n = 0;
      while (!bus.hop_1y && n < 20) begin tick(); n++; end
      check("mid_pulse_seen", 32'(bus.hop_1y), 32'd1);
      mon_abort = 1'b1;
      rst = 1'b1;
      tick();
      check("mid_rst_hop", 32'(bus.hop_1y), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      tick();
      mon_abort = 1'b0;
      exp_q.delete();
      ps0 = pulse_starts;
      repeat (10) tick();
      check("mid_after_busy", 32'(bus.busy), 32'd0);
      check("mid_after_pulses", 32'(pulse_starts - ps0), 32'd0);

      // Saturation: 31 twice -> 15 x 1Y + 1 x 0.5, done in first wait cycle
      resp_delay = 0;
      for (int i = 0; i < 15; i++) exp_q.push_back(P_1Y);
      exp_q.push_back(P_05);
      ps0 = pulse_starts;
      bus.change_in = AMT_W'(31);
      tick();
      bus.change_in = AMT_W'(31);
      tick();
      bus.change_in = '0;
      wait_quiet("sat_done", 600);
      check("sat_pulses", 32'(pulse_starts - ps0), 32'd16);
`ifdef DISPENSE_STATS_EN
      check("stat_cola", 32'(cnt_cola), 32'd0);
      check("stat_1y",   32'(cnt_1y),   32'd15);
      check("stat_05",   32'(cnt_05),   32'd1);
`endif

      // Timeout: no matching done after a 1Y pulse -> sticky fault
      do_reset();
      resp_en = 1'b0;
      exp_q.push_back(P_1Y);
      bus.change_in = AMT_W'(2);
      tick();
      bus.change_in = '0;
      n = 0;
      while (!bus.hop_1y && n < 20) begin tick(); n++; end
      check("to_pulse_seen", 32'(bus.hop_1y), 32'd1);
      n = 0;
      while (bus.hop_1y && n < 20) begin tick(); n++; end
      check("to_pulse_end", 32'(bus.hop_1y), 32'd0);   // first cycle after pulse
      check("to_fault_e0", 32'(bus.fault), 32'd0);
      for (int k = 1; k < ACK_TIMEOUT; k++) begin
         tick();
         drv_05_done   = (k == 3);                       // wrong actuators
         drv_cola_done = (k == 3);
      end
      check("to_fault_before", 32'(bus.fault), 32'd0);
      tick();
      check("to_fault_at", 32'(bus.fault), 32'd1);
      check("to_busy", 32'(bus.busy), 32'd1);
      ps0 = pulse_starts;
      bus.cola_in   = 1'b1;
      bus.change_in = AMT_W'(3);
      tick();
      bus.cola_in   = 1'b0;
      bus.change_in = '0;
      drv_1y_done   = 1'b1;
      tick();
      drv_1y_done   = 1'b0;
      repeat (20) tick();
      check("to_fault_sticky", 32'(bus.fault), 32'd1);
      check("to_drives_low", 32'({bus.cola_motor, bus.hop_1y, bus.hop_05}), 32'd0);
      check("to_no_pulses", 32'(pulse_starts - ps0), 32'd0);
      do_reset();
      check("to_rst_fault", 32'(bus.fault), 32'd0);
      check("to_rst_busy", 32'(bus.busy), 32'd0);
      ps0 = pulse_starts;
      repeat (10) tick();
      check("to_rst_no_pulses", 32'(pulse_starts - ps0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
